restoring_divider_16by8: RTL and testbench
==========================================

RESTORING_DIVIDER_16BY8 -- requirements
Module: restoring_divider_16by8

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high; clock port clk, reset port rst.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only when state is IDLE or DONE
- dividend  in  16  unsigned dividend; captured when start is accepted
- divisor  in  8  unsigned divisor; captured when start is accepted
- quotient  out  8  unsigned quotient; registered
- remainder  out  8  unsigned remainder; registered
- err  out  1  divide-by-zero or quotient overflow flag; registered
- busy  out  1  high while iterating (state RUN)
- done  out  1  one-cycle completion pulse (state DONE)
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE. Transitions:
- IDLE->RUN on accepted start.
- RUN->DONE after the 8th iteration, or after the first RUN cycle when the error fast path applies (REQ-011).
- DONE->RUN on start; otherwise DONE->IDLE.
REQ-005 Start SHALL be accepted at a rising edge where start=1 and the state is IDLE or DONE. On acceptance the block SHALL load dividend into a 16-bit partial-remainder/quotient register and divisor into an 8-bit register.
REQ-006 Start SHALL be ignored in RUN. Captured operands SHALL be unaffected by input changes after acceptance.
REQ-007 The block SHALL perform restoring division, one quotient bit per clock, MSB first, 8 iterations. Each iteration:
- Shift the {partial remainder, dividend} pair left by 1.
- Compute the 9-bit trial subtraction (partial remainder minus divisor) with an explicit carry.
- If non-negative, keep the difference and set quotient bit 1; otherwise restore and set quotient bit 0.
REQ-008 The error condition SHALL be evaluated from the captured operands: err=1 when divisor==0 or dividend[15:8]>=divisor; otherwise err=0.
REQ-009 Non-error result: quotient = floor(dividend/divisor) and remainder = dividend mod divisor, both exact in 8 bits.
REQ-010 Error result: quotient=8'hFF, remainder=dividend[7:0], err=1.
REQ-011 Latency, with start accepted at edge k:
- Normal: busy=1 after edges k..k+7; done=1 and results valid after edge k+8.
- Error fast path, only when enabled (REQ-017): done=1 after edge k+1.
REQ-012 done SHALL be high for exactly one cycle per accepted start, and SHALL never be high in the same cycle as busy.
REQ-013 quotient, remainder and err SHALL update only on entry to DONE, and SHALL hold until the next entry to DONE or reset; they SHALL NOT show intermediate values during RUN.
REQ-014 Start in DONE SHALL be accepted the same cycle done is high. This gives back-to-back operation with no idle gap: done pulses occur every 9 cycles on the normal path.

Reset
REQ-015 When rst=1 at a rising edge, the block SHALL enter IDLE and clear quotient, remainder, err, busy, done and all internal registers to 0. Reset takes priority over start.
REQ-016 Reset during RUN SHALL abort the operation with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-017 Macro DIV_EARLY_ERR_EN controls the error fast path:
- Defined: an error operation SHALL go RUN->DONE after one RUN cycle.
- Undefined: an error operation SHALL take the full 8 RUN cycles.
- Result values (REQ-010) and the err flag SHALL be identical in both builds; only latency differs.

Verification
REQ-018 dividend=16'h03E8, divisor=8'h0A -> done after edge k+8; quotient=8'h64, remainder=8'h00, err=0.
REQ-019 dividend=16'h7FFF, divisor=8'hFF -> quotient=8'h80, remainder=8'h7F, err=0.
REQ-020 Error cases:
- dividend=16'h1234, divisor=8'h00 -> quotient=8'hFF, remainder=8'h34, err=1.
- dividend=16'hFFFE, divisor=8'hFF -> err=1.
- Latency: 1 cycle with DIV_EARLY_ERR_EN defined, 8 cycles without.
REQ-021 Issue 16'h0064/8'h07 then 16'h00FF/8'h10, with the second start held during done -> results 8'h0E/8'h02 then 8'h0F/8'h0F; done pulses 9 cycles apart.
REQ-022 Assert rst at the 4th RUN cycle -> all outputs 0 next cycle and no done pulse. A start held high throughout RUN -> exactly one operation completes.

Source files
------------

// File: rtl/restoring_divider_16by8_if.sv
// rtl/restoring_divider_16by8_if.sv - request/result bundle for the 16/8 restoring divider
interface restoring_divider_16by8_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        err;
    logic        busy;
    logic        done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, err, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, err, busy, done
    );
endinterface

// File: rtl/restoring_divider_16by8.sv
// rtl/restoring_divider_16by8.sv - 16/8 unsigned restoring divider, one quotient bit per clock
// Optional macro DIV_EARLY_ERR_EN: error operations finish after a single RUN cycle.
module restoring_divider_16by8 (
    input  logic                           clk,
    input  logic                           rst,
    restoring_divider_16by8_if.slave       bus
);
`ifdef DIV_EARLY_ERR_EN
    localparam logic EarlyErr = 1'b1;
`else
    localparam logic EarlyErr = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_pend_q, err_pend_d;
    logic [7:0]  quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        err_q, err_d;

    logic [8:0]  shifted;
    logic [9:0]  trial;
    logic        borrow;
    logic [15:0] acc_step;
    logic        last_iter;
    logic        accept;

    // acc_q holds {partial remainder, remaining dividend bits / quotient bits so far}
    always_comb begin
        shifted  = {acc_q[15:8], acc_q[7]};
        trial    = {1'b0, shifted} - {2'b00, divisor_q};
        borrow   = trial[9];
        acc_step = borrow ? {shifted[7:0], acc_q[6:0], 1'b0}
                          : {trial[7:0],   acc_q[6:0], 1'b1};
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        err_d      = err_q;
        accept     = 1'b0;
        last_iter  = (cnt_q == 3'd7) || (EarlyErr && err_pend_q);

        case (state_q)
            IDLE: accept = bus.start;
            DONE: begin
                accept  = bus.start;
                state_d = IDLE;
            end
            RUN: begin
                cnt_d = cnt_q + 3'd1;
                // Error operations leave acc untouched so the low dividend byte survives as remainder
                if (!err_pend_q) begin
                    acc_d = acc_step;
                end
                if (last_iter) begin
                    state_d = DONE;
                    quot_d  = err_pend_q ? 8'hFF : acc_d[7:0];
                    rem_d   = err_pend_q ? acc_d[7:0] : acc_d[15:8];
                    err_d   = err_pend_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d    = RUN;
            acc_d      = bus.dividend;
            divisor_d  = bus.divisor;
            cnt_d      = 3'd0;
            err_pend_d = (bus.divisor == 8'd0) || (bus.dividend[15:8] >= bus.divisor);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= 16'd0;
            divisor_q  <= 8'd0;
            cnt_q      <= 3'd0;
            err_pend_q <= 1'b0;
            quot_q     <= 8'd0;
            rem_q      <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_restoring_divider_16by8.sv
// tb/tb_restoring_divider_16by8.sv - scoreboard bench for restoring_divider_16by8
module tb_restoring_divider_16by8;
    logic clk;
    logic rst;
    restoring_divider_16by8_if bus ();

    restoring_divider_16by8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    exp_t prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
        exp_t x;
        if (dv == 8'd0 || dd[15:8] >= dv) begin
            x.q = 8'hFF;
            x.r = dd[7:0];
            x.e = 1'b1;
`ifdef DIV_EARLY_ERR_EN
            x.lat = 1;
`else
            x.lat = 8;
`endif
        end else begin
            x.q   = 8'(dd / {8'd0, dv});
            x.r   = 8'(dd % {8'd0, dv});
            x.e   = 1'b0;
            x.lat = 8;
        end
        return x;
    endfunction

    task automatic drive_start(input logic [15:0] dd, input logic [7:0] dv);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        sb.push_back(model(dd, dv));
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        x = sb.pop_front();
        check({tag, "_q"}, 32'(bus.quotient), 32'(x.q));
        check({tag, "_r"}, 32'(bus.remainder), 32'(x.r));
        check({tag, "_err"}, 32'(bus.err), 32'(x.e));
        prev = x;
    endtask

    // Called at the negedge right after the accepting edge; returns cycles until done.
    task automatic wait_done(input string tag, output int lat);
        lat = -1;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_hold_q"}, 32'(bus.quotient), 32'(prev.q));
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                check({tag, "_no_busy_at_done"}, 32'(bus.busy), 32'd0);
                break;
            end
        end
        if (lat < 0) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv);
        int lat;
        int exp_lat;
        @(negedge clk);
        drive_start(dd, dv);
        exp_lat = sb[sb.size()-1].lat;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = ~dd;
        bus.divisor  = ~dv;
        wait_done(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        pop_check(tag);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat;
        int done_cnt;
        prev = '{q: 8'd0, r: 8'd0, e: 1'b0, lat: 0};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        run_op("r018", 16'h03E8, 8'h0A);
        run_op("r019", 16'h7FFF, 8'hFF);
        run_op("err_div0", 16'h1234, 8'h00);
        run_op("err_ovf", 16'hFFFE, 8'hFF);
        run_op("edge_max", 16'hFEFF, 8'hFF);
        run_op("edge_eq", 16'h0500, 8'h05);
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  dv;
            logic [15:0] dd;
            dv = 8'($urandom_range(1, 255));
            dd = {8'($urandom_range(0, 32'(dv) - 1)), 8'($urandom)};
            run_op($sformatf("rand%0d", i), dd, dv);
        end

        // back-to-back: second start presented while done is high
        @(negedge clk);
        drive_start(16'h0064, 8'h07);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_a", lat);
        check("b2b_a_lat", 32'(lat), 32'd8);
        pop_check("b2b_a");
        drive_start(16'h00FF, 8'h10);
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (bus.done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        check("b2b_gap", 32'(lat), 32'd9);
        pop_check("b2b_b");

        // reset in the 4th RUN cycle aborts with no done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'h03E8;
        bus.divisor = 8'h0A;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_q", 32'(bus.quotient), 32'd0);
        check("abort_r", 32'(bus.remainder), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        check("abort_busy0", 32'(bus.busy), 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        prev = '{q: 8'd0, r: 8'd0, e: 1'b0, lat: 0};
        run_op("post_rst", 16'h1000, 8'h21);

        // start held throughout RUN: only one operation completes
        @(negedge clk);
        drive_start(16'h2710, 8'h64);
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            bus.dividend = 16'(n * 16'h0111);
            if (bus.done) begin
                done_cnt++;
                pop_check("held");
                bus.start = 1'b0;
                break;
            end
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("held_one_done", 32'(done_cnt), 32'd1);
        check("held_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
